// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the uart_tx arbiter.
//   txa_state_e : sequencer states (IDLE waits for data and an idle uart,
//                 LAUNCH holds tx_en until the uart takes the byte,
//                 DRAIN waits for the uart to finish the frame)
//   rr_sel_e    : identity of the requester that won the last push
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        TXA_IDLE   = 2'd0,
        TXA_LAUNCH = 2'd1,
        TXA_DRAIN  = 2'd2
    } txa_state_e;

    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_sel_e;

endpackage

// File: rtl/uart_tx_arbiter_fifo.sv
// sync_fifo_8: circular byte FIFO with a combinationally readable head.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   push, din    write din at the tail (caller guarantees room or a same-cycle pop)
//   pop, dout    dout is the current head; pop advances past it
//   flush        empties the FIFO (pointers and count to zero)
//   count        number of stored bytes, 0..DEPTH
module sync_fifo_8
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [AW:0]   count
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is data only; it needs no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between requester A (CPU stores) and
// requester B (debug/trace). Requests are granted round-robin into a FIFO and
// a sequencer drains the FIFO through the uart tx_byte/tx_en/tx_ready handshake.
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   a_valid/a_byte       requester A offer;  a_ready = accepted this cycle
//   b_valid/b_byte       requester B offer;  b_ready = accepted this cycle
//   flush                discard all queued bytes (in-flight byte still completes)
//   tx_ready             uart idle
//   tx_en/tx_byte        uart start strobe / byte, tx_byte stable for the frame
//   fifo_count           queued bytes, 0..DEPTH
//   busy                 FIFO non-empty or sequencer not idle
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic [7:0]    a_byte,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [7:0]    b_byte,
    output logic          b_ready,
    input  logic          flush,
    input  logic          tx_ready,
    output logic          tx_en,
    output logic [7:0]    tx_byte,
    output logic [AW:0]   fifo_count,
    output logic          busy
);

    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    txa_state_e  state_q, state_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    rr_sel_e     rr_last_q, rr_last_d;

    logic [AW:0] count;
    logic [7:0]  head;
    logic        pop;
    logic        room;
    logic        grant_a;
    logic        grant_b;
    logic        push;
    logic [7:0]  push_byte;

    // A pop is blocked by flush so a byte being discarded is never launched.
    assign pop  = !rst && !flush && (state_q == TXA_IDLE) && (count != '0) && tx_ready;

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign room = !rst && !flush && ((count < DEPTH_CNT) || pop);

    assign grant_a   = room && a_valid && (!b_valid || (rr_last_q == RR_B));
    assign grant_b   = room && b_valid && (!a_valid || (rr_last_q == RR_A));
    assign push      = grant_a || grant_b;
    assign push_byte = grant_a ? a_byte : b_byte;

    sync_fifo_8 #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (push_byte),
        .dout  (head),
        .count (count)
    );

    always_comb begin
        rr_last_d = rr_last_q;
        if (grant_a)      rr_last_d = RR_A;
        else if (grant_b) rr_last_d = RR_B;
    end

    always_comb begin
        state_d   = state_q;
        tx_en_d   = tx_en_q;
        tx_byte_d = tx_byte_q;
        case (state_q)
            TXA_IDLE: begin
                tx_en_d = 1'b0;
                if (pop) begin
                    state_d   = TXA_LAUNCH;
                    tx_en_d   = 1'b1;
                    tx_byte_d = head;
                end
            end
            TXA_LAUNCH: begin
                tx_en_d = 1'b1;
                // tx_ready falling means the uart has latched the byte.
                if (!tx_ready) begin
                    state_d = TXA_DRAIN;
                    tx_en_d = 1'b0;
                end
            end
            TXA_DRAIN: begin
                tx_en_d = 1'b0;
                if (tx_ready) state_d = TXA_IDLE;
            end
            default: begin
                state_d = TXA_IDLE;
                tx_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= TXA_IDLE;
            tx_en_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            rr_last_q <= RR_B;
        end else begin
            state_q   <= state_d;
            tx_en_q   <= tx_en_d;
            tx_byte_q <= tx_byte_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign tx_en      = tx_en_q;
    assign tx_byte    = tx_byte_q;
    assign fifo_count = count;
    assign busy       = (count != '0) || (state_q != TXA_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_valid = 1'b0;
    logic [7:0]    a_byte = 8'h00;
    logic          a_ready;
    logic          b_valid = 1'b0;
    logic [7:0]    b_byte = 8'h00;
    logic          b_ready;
    logic          flush = 1'b0;
    logic          tx_ready = 1'b1;
    logic          tx_en;
    logic [7:0]    tx_byte;
    logic [AW:0]   fifo_count;
    logic          busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_byte     (a_byte),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_byte     (b_byte),
        .b_ready    (b_ready),
        .flush      (flush),
        .tx_ready   (tx_ready),
        .tx_en      (tx_en),
        .tx_byte    (tx_byte),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: queue contents, round-robin memory, transmission status.
    logic [7:0] fq[$];        // bytes waiting in the FIFO
    logic [7:0] exp_tx[$];    // scoreboard: bytes in the order they must be launched
    bit         rr_b;         // last winner was B
    bit         in_flight;    // a byte has left the FIFO and its frame is not finished
    bit         handed;       // the uart has taken the in-flight byte
    logic [7:0] exp_txb;
    bit         known = 0;

    // Requesters and uart model.
    logic [7:0] a_src[$];
    logic [7:0] b_src[$];
    int         a_prob = 100, b_prob = 100, flush_pct = 0;
    bit         a_acc = 0, b_acc = 0;
    bit         rst_req = 1, flush_req = 0, hold_busy = 0, en_seen = 0;
    int         uart_cnt = 0, frame_min = 2, frame_max = 2;

    task automatic drive();
        rst   = rst_req;
        flush = flush_req || (flush_pct > 0 && $urandom_range(99) < flush_pct);
        if (a_acc) a_valid = 1'b0;
        if (b_acc) b_valid = 1'b0;
        if (!a_valid && a_src.size() > 0 && $urandom_range(99) < a_prob) begin
            a_valid = 1'b1;
            a_byte  = a_src.pop_front();
        end
        if (!b_valid && b_src.size() > 0 && $urandom_range(99) < b_prob) begin
            b_valid = 1'b1;
            b_byte  = b_src.pop_front();
        end
        // uart latches a byte when it saw tx_en while idle, then stays busy for a frame
        if (en_seen && tx_ready) uart_cnt = $urandom_range(frame_max, frame_min);
        else if (uart_cnt > 0)   uart_cnt--;
        tx_ready = (uart_cnt == 0) && !hold_busy;
    endtask

    task automatic eval();
        bit pop, room, ga, gb;
        pop  = !rst && !flush && !in_flight && fq.size() > 0 && tx_ready;
        room = !rst && !flush && (fq.size() < DEPTH || pop);
        ga   = room && a_valid && (!b_valid || rr_b);
        gb   = room && b_valid && (!a_valid || !rr_b);
        check("a_ready", a_ready, ga);
        check("b_ready", b_ready, gb);
        if (known) begin
            check("fifo_count", fifo_count, fq.size());
            check("busy", busy, (fq.size() != 0) || in_flight);
            check("tx_en", tx_en, in_flight && !handed);
            check("tx_byte", tx_byte, exp_txb);
        end
        en_seen = (tx_en === 1'b1);
        if (rst) begin
            fq.delete();
            rr_b      = 1;
            in_flight = 0;
            handed    = 0;
            exp_txb   = 8'h00;
            known     = 1;
        end else begin
            if (in_flight) begin
                if (!handed) begin
                    if (!tx_ready) handed = 1;
                end else if (tx_ready) begin
                    in_flight = 0;
                    handed    = 0;
                end
            end
            if (pop) begin
                exp_txb = fq.pop_front();
                exp_tx.push_back(exp_txb);
                in_flight = 1;
                handed    = 0;
            end
            if (ga) begin fq.push_back(a_byte); rr_b = 0; end
            if (gb) begin fq.push_back(b_byte); rr_b = 1; end
            if (flush) fq.delete();
        end
        a_acc = ga;
        b_acc = gb;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        eval();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_req = 1;
        run(2);
        rst_req = 0;
    endtask

    task automatic drain_wait(input string name, input int budget);
        int k = 0;
        while ((a_src.size() > 0 || b_src.size() > 0 || a_valid || b_valid ||
                fq.size() > 0 || in_flight) && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (k >= budget) begin
            failures++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, k);
        end
    endtask

    // Monitor: every launch (tx_en rising) must carry the next expected byte.
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        if (tx_en === 1'b1 && prev_en !== 1'b1) begin
            if (exp_tx.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_launch: unexpected tx_en with byte 0x%0h, required none", tx_byte);
            end else begin
                check("tx_launch_order", tx_byte, exp_tx.pop_front());
            end
        end
        prev_en = tx_en;
    end

    initial begin
        int k;
        // Single byte from A, offered during reset; uart idle.
        a_src.push_back(8'h41);
        frame_min = 3; frame_max = 3;
        run(3);
        rst_req = 0;
        drain_wait("single_a", 40);

        // Both requesters always valid: grants alternate starting with A.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            a_src.push_back(8'hA0 + 8'(i));
            b_src.push_back(8'hB0 + 8'(i));
        end
        frame_min = 2; frame_max = 5;
        drain_wait("alternate", 300);

        // Uart held busy: 8 bytes fill the FIFO, the 9th waits for a pop.
        do_reset();
        hold_busy = 1;
        for (int i = 0; i < 9; i++) a_src.push_back(8'hC0 + 8'(i));
        run(14);
        check("full_count", fifo_count, 8);
        check("full_a_ready", a_ready, 0);
        hold_busy = 0;
        step();
        check("full_pop_cycle_a_ready", a_ready, 1);
        drain_wait("full_release", 200);

        // 16 ordered bytes through the uart, wrapping the pointers.
        do_reset();
        for (int i = 0; i < 16; i++) a_src.push_back(8'(i));
        a_prob = 70; frame_min = 1; frame_max = 4;
        drain_wait("stream", 400);
        a_prob = 100;

        // Flush with 5 queued bytes while a frame drains.
        do_reset();
        for (int i = 0; i < 6; i++) a_src.push_back(8'hD0 + 8'(i));
        frame_min = 10; frame_max = 10;
        k = 0;
        while (!(in_flight && handed && fq.size() == 5) && k < 40) begin
            step();
            k++;
        end
        checks++;
        if (k >= 40) begin
            failures++;
            $display("FAIL flush_setup: count=5 in drain not reached, actual count=%0d", fifo_count);
        end
        flush_req = 1;
        step();
        flush_req = 0;
        step();
        check("flush_count", fifo_count, 0);
        drain_wait("flush_drain", 60);

        // Reset while tx_en is asserted, then a fresh byte.
        do_reset();
        for (int i = 0; i < 4; i++) a_src.push_back(8'hE0 + 8'(i));
        frame_min = 3; frame_max = 3;
        k = 0;
        while (!(in_flight && !handed && fq.size() > 0) && k < 20) begin
            step();
            k++;
        end
        checks++;
        if (k >= 20) begin
            failures++;
            $display("FAIL rst_setup: launch with queued bytes not reached, actual count=%0d", fifo_count);
        end
        rst_req = 1;
        step();
        rst_req = 0;
        step();
        check("rst_launch_tx_en", tx_en, 0);
        check("rst_launch_busy", busy, 0);
        a_src.push_back(8'h5A);
        drain_wait("after_rst", 100);

        // Random mix with occasional flushes.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            a_src.push_back(8'($urandom));
            b_src.push_back(8'($urandom));
        end
        a_prob = 60; b_prob = 60; flush_pct = 3; frame_min = 1; frame_max = 5;
        drain_wait("random", 3000);
        flush_pct = 0;
        run(10);

        check("tx_all_launched", exp_tx.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
